// File: rtl/wb_stage_reg.sv
// Writeback stage register: holds the four writeback-mux candidates and waits for load data.
// Optional macro WB_LOAD_EXT_EN adds load alignment and sign/zero extension.
module wb_stage_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [1:0]        in_wb_sel,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_addr_lo,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [DATA_W-1:0] out_pc4,
  output logic [DATA_W-1:0] out_imm,
  output logic [1:0]        out_wb_sel,
  output logic [4:0]        out_rd,
  output logic              out_reg_write
);

  typedef enum logic [1:0] {IDLE, WAIT_LD, VALID} state_t;

  state_t            state, next_state;
  logic              accept;
  logic              load_done;
  logic              valid_d;
  logic              reg_write_d;
  logic              cap_reg_write;
  logic [DATA_W-1:0] load_data;

  assign in_ready  = (state != WAIT_LD);
  assign accept    = in_valid && in_ready && !flush;
  assign load_done = (state == WAIT_LD) && dmem_rvalid && !flush;

`ifdef WB_LOAD_EXT_EN
  logic [2:0]        cap_funct3;
  logic [1:0]        cap_addr_lo;
  logic [DATA_W-1:0] shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_funct3  <= 3'b000;
      cap_addr_lo <= 2'b00;
    end else if (accept) begin
      cap_funct3  <= in_funct3;
      cap_addr_lo <= in_addr_lo;
    end
  end

  // Bring the addressed byte/halfword down to bit 0, then extend by load type.
  always_comb begin
    shifted   = dmem_rdata >> {cap_addr_lo, 3'b000};
    load_data = dmem_rdata;
    case (cap_funct3)
      3'b000:  load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end
`else
  logic unused_load_cfg;

  assign unused_load_cfg = ^{in_funct3, in_addr_lo};
  assign load_data       = dmem_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state plus the next values of the registered handshake outputs; flush wins.
  always_comb begin
    next_state  = state;
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    case (state)
      IDLE, VALID: begin
        next_state = IDLE;
        if (accept) begin
          next_state  = in_is_load ? WAIT_LD : VALID;
          valid_d     = !in_is_load;
          reg_write_d = !in_is_load && in_reg_write && (in_rd != 5'd0);
        end
      end
      WAIT_LD: begin
        if (dmem_rvalid) begin
          next_state  = VALID;
          valid_d     = 1'b1;
          reg_write_d = cap_reg_write;
        end
      end
      default: next_state = IDLE;
    endcase
    if (flush) begin
      next_state  = IDLE;
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_alu       <= '0;
      out_mem       <= '0;
      out_pc4       <= '0;
      out_imm       <= '0;
      out_wb_sel    <= 2'b00;
      out_rd        <= 5'd0;
      cap_reg_write <= 1'b0;
    end else begin
      out_valid     <= valid_d;
      out_reg_write <= reg_write_d;
      if (accept) begin
        out_alu       <= in_alu;
        out_pc4       <= in_pc4;
        out_imm       <= in_imm;
        out_wb_sel    <= in_wb_sel;
        out_rd        <= in_rd;
        cap_reg_write <= in_reg_write && (in_rd != 5'd0);
      end
      if (load_done) out_mem <= load_data;
    end
  end

endmodule

// File: tb/tb_wb_stage_reg.sv
// Bench for wb_stage_reg: table-driven retire sequence with a scoreboard, plus hand-written corners.
module tb_wb_stage_reg;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu, in_pc4, in_imm;
  logic [1:0]        in_wb_sel;
  logic [4:0]        in_rd;
  logic              in_reg_write, in_is_load;
  logic [2:0]        in_funct3;
  logic [1:0]        in_addr_lo;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_alu, out_mem, out_pc4, out_imm;
  logic [1:0]        out_wb_sel;
  logic [4:0]        out_rd;
  logic              out_reg_write;

  wb_stage_reg #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_pc4(in_pc4), .in_imm(in_imm), .in_wb_sel(in_wb_sel),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .flush(flush), .out_valid(out_valid),
    .out_alu(out_alu), .out_mem(out_mem), .out_pc4(out_pc4), .out_imm(out_imm),
    .out_wb_sel(out_wb_sel), .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, mem, pc4, imm;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  typedef struct {
    logic        is_load;
    logic [31:0] alu, pc4, imm;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] rdata;
    int          delay;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[8];
  logic [31:0] last_mem;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_mem(input logic [31:0] rdata, input logic [2:0] f3,
                                          input logic [1:0] a);
`ifdef WB_LOAD_EXT_EN
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*int'(a) +: 8];
    h = (a == 2'd0) ? rdata[15:0] : rdata[31:16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rdata;
    endcase
`else
    return (f3 == 3'b111 && a == 2'd3) ? rdata : rdata;
`endif
  endfunction

  // Pop and compare one expected record whenever the DUT presents a retired instruction.
  task automatic monitor();
    exp_t e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got out_valid=1 expected no retire at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_alu", out_alu, e.alu);
        check("sb_mem", out_mem, e.mem);
        check("sb_pc4", out_pc4, e.pc4);
        check("sb_imm", out_imm, e.imm);
        check("sb_wb_sel", 32'(out_wb_sel), 32'(e.sel));
        check("sb_rd", 32'(out_rd), 32'(e.rd));
        check("sb_reg_write", 32'(out_reg_write), 32'(e.rw));
      end
    end else begin
      check("reg_write_idle", 32'(out_reg_write), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic set_fields(input logic ld, input logic [31:0] alu, input logic [31:0] pc4,
                            input logic [31:0] imm, input logic [1:0] sel, input logic [4:0] rd,
                            input logic rw, input logic [2:0] f3, input logic [1:0] a);
    in_valid = 1'b1; in_is_load = ld; in_alu = alu; in_pc4 = pc4; in_imm = imm;
    in_wb_sel = sel; in_rd = rd; in_reg_write = rw; in_funct3 = f3; in_addr_lo = a;
  endtask

  task automatic push(input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                      input logic [1:0] sel, input logic [4:0] rd, input logic rw);
    exp_t e;
    e.alu = alu; e.mem = last_mem; e.pc4 = pc4; e.imm = imm;
    e.sel = sel; e.rd = rd; e.rw = rw && (rd != 5'd0);
    exp_q.push_back(e);
  endtask

  task automatic nonload(input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [1:0] sel, input logic [4:0] rd, input logic rw);
    set_fields(1'b0, alu, pc4, imm, sel, rd, rw, 3'b010, 2'd0);
    push(alu, pc4, imm, sel, rd, rw);
    step();
    check("nl_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic load(input vec_t v);
    set_fields(1'b1, v.alu, v.pc4, v.imm, v.sel, v.rd, v.rw, v.f3, v.a);
    step();
    in_valid = 1'b0; in_is_load = 1'b0;
    check("ld_accept_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < v.delay; i++) begin
      check("ld_ready_wait", 32'(in_ready), 32'd0);
      step();
    end
    check("ld_ready_wait", 32'(in_ready), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
    last_mem = exp_mem(v.rdata, v.f3, v.a);
    push(v.alu, v.pc4, v.imm, v.sel, v.rd, v.rw);
    step();
    dmem_rvalid = 1'b0;
    check("ld_retire_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_is_load = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_alu"}, out_alu, 32'd0);
    check({tag, "_mem"}, out_mem, 32'd0);
    check({tag, "_pc4"}, out_pc4, 32'd0);
    check({tag, "_imm"}, out_imm, 32'd0);
    check({tag, "_sel_rd_rw"}, {25'd0, out_wb_sel, out_rd}, 32'd0);
    check({tag, "_reg_write"}, 32'(out_reg_write), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    //           ld    alu           pc4           imm           sel rd     rw    f3      a     rdata         dly
    vecs[0] = '{1'b0, 32'h0000_1234, 32'h0000_0104, 32'h0000_0aaa, 2'd0, 5'd1,  1'b1, 3'b010, 2'd0, 32'h0,         0};
    vecs[1] = '{1'b0, 32'hffff_0001, 32'h0000_0108, 32'hffff_f800, 2'd3, 5'd31, 1'b1, 3'b010, 2'd0, 32'h0,         0};
    vecs[2] = '{1'b1, 32'h0000_2000, 32'h0000_010c, 32'h0000_0010, 2'd1, 5'd7,  1'b1, 3'b010, 2'd0, 32'hcafe_f00d, 0};
    vecs[3] = '{1'b0, 32'h5555_aaaa, 32'h0000_0110, 32'h0000_0001, 2'd2, 5'd0,  1'b1, 3'b010, 2'd0, 32'h0,         0};
    vecs[4] = '{1'b1, 32'h0000_2002, 32'h0000_0114, 32'h0000_0002, 2'd1, 5'd9,  1'b1, 3'b001, 2'd2, 32'h8001_7fff, 1};
    vecs[5] = '{1'b1, 32'h0000_2001, 32'h0000_0118, 32'h0000_0001, 2'd1, 5'd10, 1'b0, 3'b100, 2'd1, 32'h1234_c678, 4};
    vecs[6] = '{1'b0, 32'h0bad_f00d, 32'h0000_011c, 32'h7fff_ffff, 2'd0, 5'd12, 1'b0, 3'b010, 2'd0, 32'h0,         0};
    vecs[7] = '{1'b0, 32'h0000_0042, 32'h0000_0120, 32'h0000_0003, 2'd3, 5'd13, 1'b1, 3'b010, 2'd0, 32'h0,         0};

    last_mem = 32'd0;
    rst = 1'b1; flush = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h1111_2222;
    set_fields(1'b1, 32'h9, 32'h9, 32'h9, 2'd1, 5'd3, 1'b1, 3'b000, 2'd1);
    @(posedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    check_all_zero("reset_hold");
    rst = 1'b0;

    // Basic non-load retires with latency one and then drops.
    nonload(32'h11, 32'h4, 32'h0, 2'd0, 5'd5, 1'b1);
    check("basic_reg_write", 32'(out_reg_write), 32'd1);
    idle();
    check("basic_drop_valid", 32'(out_valid), 32'd0);

    // LW with rvalid three cycles after accept.
    v = '{1'b1, 32'h100, 32'h8, 32'h0, 2'd1, 5'd6, 1'b1, 3'b010, 2'd0, 32'hdead_beef, 2};
    load(v);
    check("lw_out_mem", out_mem, exp_mem(32'hdead_beef, 3'b010, 2'd0));
    idle();
    check("lw_drop_valid", 32'(out_valid), 32'd0);

`ifdef WB_LOAD_EXT_EN
    v = '{1'b1, 32'h200, 32'hc, 32'h0, 2'd1, 5'd8, 1'b1, 3'b000, 2'd3, 32'h80ff_0000, 0};
    load(v);
    check("lb_ext", out_mem, 32'hffff_ff80);
    v.f3 = 3'b100;
    load(v);
    check("lbu_ext", out_mem, 32'h0000_0080);
    idle();
`endif

    // rvalid outside WAIT_LD is ignored.
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5a5a_5a5a;
    idle();
    dmem_rvalid = 1'b0;
    check("stray_rvalid_valid", 32'(out_valid), 32'd0);
    check("stray_rvalid_mem", out_mem, last_mem);

    // Table: back-to-back mix of loads and non-loads.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_load) load(vecs[i]);
      else nonload(vecs[i].alu, vecs[i].pc4, vecs[i].imm, vecs[i].sel, vecs[i].rd, vecs[i].rw);
    end
    idle();
    check("table_drop_valid", 32'(out_valid), 32'd0);

    // Flush with rvalid in the same WAIT_LD cycle discards the load.
    set_fields(1'b1, 32'h300, 32'h10, 32'h0, 2'd1, 5'd4, 1'b1, 3'b010, 2'd0);
    step();
    in_valid = 1'b0;
    flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    step();
    flush = 1'b0; dmem_rvalid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_reg_write", 32'(out_reg_write), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    check("flush_mem_kept", out_mem, last_mem);
    idle();
    check("flush_after_valid", 32'(out_valid), 32'd0);

    // Flush blocks an otherwise valid accept.
    set_fields(1'b0, 32'h400, 32'h14, 32'h0, 2'd0, 5'd2, 1'b1, 3'b010, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_accept_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset in WAIT_LD, then back-to-back non-loads.
    set_fields(1'b1, 32'h500, 32'h18, 32'h44, 2'd1, 5'd3, 1'b1, 3'b010, 2'd0);
    step();
    in_valid = 1'b0; in_is_load = 1'b0;
    check("pre_rst_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1 rst = 1'b0;
    last_mem = 32'd0;
    nonload(32'h601, 32'h1c, 32'h1, 2'd0, 5'd1, 1'b1);
    nonload(32'h602, 32'h20, 32'h2, 2'd2, 5'd0, 1'b1);
    nonload(32'h603, 32'h24, 32'h3, 2'd3, 5'd2, 1'b1);
    idle();
    check("rst_b2b_drop", 32'(out_valid), 32'd0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
